// File: rtl/ped_xing_ctrl.sv
// Pedestrian crossing controller: main-road signal plus walk/don't-walk head, one down-counting phase timer.
// Optional flashing don't-walk clearance phase is built when PED_FLASH_EN is defined.
module ped_xing_ctrl #(
   parameter int CNT_W      = 8,
   parameter int GREEN_MIN  = 8,
   parameter int YELLOW_T   = 3,
   parameter int ALLRED_T   = 2,
   parameter int WALK_T     = 5,
   parameter int CLEAR_T    = 4,
   parameter int FLASH_HALF = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   output logic       main_r,
   output logic       main_y,
   output logic       main_g,
   output logic       ped_walk,
   output logic       ped_dw,
   output logic [2:0] state,
   output logic       req_pending
);

   typedef enum logic [2:0] {
      S_MAIN_GREEN  = 3'd0,
      S_MAIN_YELLOW = 3'd1,
      S_ALL_RED1    = 3'd2,
      S_PED_WALK    = 3'd3,
      S_PED_CLEAR   = 3'd4,
      S_ALL_RED2    = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(WALK_T - 1);
`ifdef PED_FLASH_EN
   localparam logic [CNT_W-1:0] LD_CLEAR  = CNT_W'(CLEAR_T - 1);
   localparam logic [CNT_W-1:0] LD_HALF   = CNT_W'(FLASH_HALF - 1);
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             req_q, req_d;
   logic             timer_zero;
   logic             entering;

   function automatic logic [CNT_W-1:0] load_for(input state_e s);
      logic [CNT_W-1:0] v;
      v = LD_GREEN;
      case (s)
         S_MAIN_YELLOW: v = LD_YELLOW;
         S_ALL_RED1:    v = LD_ALLRED;
         S_PED_WALK:    v = LD_WALK;
`ifdef PED_FLASH_EN
         S_PED_CLEAR:   v = LD_CLEAR;
`endif
         S_ALL_RED2:    v = LD_ALLRED;
         default:       v = LD_GREEN;
      endcase
      return v;
   endfunction

   // Next phase, timer and request latch; any unreachable code falls back to main green.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      req_d      = req_q;
      timer_zero = (timer_q == '0);
      case (state_q)
         S_MAIN_GREEN:  if (timer_zero && req_q) state_d = S_MAIN_YELLOW;
         S_MAIN_YELLOW: if (timer_zero) state_d = S_ALL_RED1;
         S_ALL_RED1:    if (timer_zero) state_d = S_PED_WALK;
`ifdef PED_FLASH_EN
         S_PED_WALK:    if (timer_zero) state_d = S_PED_CLEAR;
         S_PED_CLEAR:   if (timer_zero) state_d = S_ALL_RED2;
`else
         S_PED_WALK:    if (timer_zero) state_d = S_ALL_RED2;
`endif
         S_ALL_RED2:    if (timer_zero) state_d = S_MAIN_GREEN;
         default:       state_d = S_MAIN_GREEN;
      endcase

      entering = (state_d != state_q);
      if (entering) begin
         timer_d = load_for(state_d);
      end else if (!timer_zero) begin
         timer_d = timer_q - 1'b1;
      end

      // Entering walk serves the request and beats a same-cycle press.
      if (entering && (state_d == S_PED_WALK)) begin
         req_d = 1'b0;
      end else if (btn && (state_q != S_PED_WALK)) begin
         req_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_MAIN_GREEN;
         timer_q <= LD_GREEN;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         req_q   <= req_d;
      end
   end

`ifdef PED_FLASH_EN
   logic             flash_q, flash_d;
   logic [CNT_W-1:0] fdiv_q, fdiv_d;

   always_comb begin
      flash_d = flash_q;
      fdiv_d  = fdiv_q;
      if ((state_d == S_PED_CLEAR) && (state_q != S_PED_CLEAR)) begin
         flash_d = 1'b1;
         fdiv_d  = LD_HALF;
      end else if (state_q == S_PED_CLEAR) begin
         if (fdiv_q == '0) begin
            flash_d = ~flash_q;
            fdiv_d  = LD_HALF;
         end else begin
            fdiv_d = fdiv_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flash_q <= 1'b1;
         fdiv_q  <= '0;
      end else begin
         flash_q <= flash_d;
         fdiv_q  <= fdiv_d;
      end
   end
`endif

   // Lamps decode registered state only; red covers every non-green, non-yellow code.
   always_comb begin
      main_g   = (state_q == S_MAIN_GREEN);
      main_y   = (state_q == S_MAIN_YELLOW);
      main_r   = ~(main_g | main_y);
      ped_walk = (state_q == S_PED_WALK);
      ped_dw   = ~ped_walk;
`ifdef PED_FLASH_EN
      if (state_q == S_PED_CLEAR) ped_dw = flash_q;
`endif
   end

   assign state       = state_q;
   assign req_pending = req_q;

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// Bench for ped_xing_ctrl: directed test-plan scenarios then random button traffic,
// all checked against a phase/elapsed-time reference model (honours PED_FLASH_EN).
module tb_ped_xing_ctrl;

   localparam int GREEN_MIN  = 8;
   localparam int YELLOW_T   = 3;
   localparam int ALLRED_T   = 2;
   localparam int WALK_T     = 5;
   localparam int CLEAR_T    = 4;
   localparam int FLASH_HALF = 1;
`ifdef PED_FLASH_EN
   localparam bit FLASH = 1'b1;
`else
   localparam bit FLASH = 1'b0;
`endif
   // First cycle of main green after a service that starts at the earliest yellow.
   localparam int RET = GREEN_MIN + YELLOW_T + 2 * ALLRED_T + WALK_T + (FLASH ? CLEAR_T : 0);

   localparam int P_GREEN = 0, P_YELLOW = 1, P_AR1 = 2, P_WALK = 3, P_CLEAR = 4, P_AR2 = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn = 1'b0;
   logic       main_r, main_y, main_g, ped_walk, ped_dw, req_pending;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int m_phase;
   int m_elapsed;
   bit m_req;

   ped_xing_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .btn         (btn),
      .main_r      (main_r),
      .main_y      (main_y),
      .main_g      (main_g),
      .ped_walk    (ped_walk),
      .ped_dw      (ped_dw),
      .state       (state),
      .req_pending (req_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
      end
   endtask

   function automatic int phase_len(input int p);
      case (p)
         P_YELLOW: return YELLOW_T;
         P_AR1:    return ALLRED_T;
         P_WALK:   return WALK_T;
         P_CLEAR:  return CLEAR_T;
         P_AR2:    return ALLRED_T;
         default:  return GREEN_MIN;
      endcase
   endfunction

   function automatic int next_phase(input int p);
      case (p)
         P_GREEN:  return P_YELLOW;
         P_YELLOW: return P_AR1;
         P_AR1:    return P_WALK;
         P_WALK:   return FLASH ? P_CLEAR : P_AR2;
         P_CLEAR:  return P_AR2;
         default:  return P_GREEN;
      endcase
   endfunction

   task automatic model_step(input bit b, input bit r);
      bit nreq;
      bit done;
      if (r) begin
         m_phase   = P_GREEN;
         m_elapsed = 0;
         m_req     = 1'b0;
         return;
      end
      nreq = m_req | (b && (m_phase != P_WALK));
      if (m_phase == P_GREEN) done = ((m_elapsed + 1) >= GREEN_MIN) && m_req;
      else done = ((m_elapsed + 1) == phase_len(m_phase));
      if (done) begin
         m_phase   = next_phase(m_phase);
         m_elapsed = 0;
         if (m_phase == P_WALK) nreq = 1'b0;
      end else if (m_elapsed < 1000000) begin
         m_elapsed++;
      end
      m_req = nreq;
   endtask

   task automatic check_model();
      bit exp_dw;
      if (m_phase == P_WALK) exp_dw = 1'b0;
      else if (m_phase == P_CLEAR) exp_dw = ((m_elapsed / FLASH_HALF) % 2) == 0;
      else exp_dw = 1'b1;
      chk("state", 8'(state), 8'(m_phase));
      chk("main_g", 8'(main_g), 8'(m_phase == P_GREEN));
      chk("main_y", 8'(main_y), 8'(m_phase == P_YELLOW));
      chk("main_r", 8'(main_r), 8'(m_phase >= P_AR1));
      chk("ped_walk", 8'(ped_walk), 8'(m_phase == P_WALK));
      chk("ped_dw", 8'(ped_dw), 8'(exp_dw));
      chk("req_pending", 8'(req_pending), 8'(m_req));
      chk("main_one_hot", 8'(int'(main_r) + int'(main_y) + int'(main_g)), 8'd1);
      chk("walk_excl", 8'(ped_walk & (main_g | main_y)), 8'd0);
   endtask

   task automatic tick(input bit b, input bit r);
      check_model();
      btn   = b;
      reset = r;
      model_step(b, r);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      btn   = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_step(1'b0, 1'b1);
      cyc = 0;
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_state", 8'(state), 8'd0);
      chk("rst_main_g", 8'(main_g), 8'd1);
      chk("rst_ped_dw", 8'(ped_dw), 8'd1);
      chk("rst_req", 8'(req_pending), 8'd0);
      chk("rst_others", 8'({main_r, main_y, ped_walk}), 8'd0);

      // Early request
      for (int c = 0; c < 30; c++) begin
         chk("early_g", 8'(main_g), 8'(c <= 7 || c >= RET));
         chk("early_y", 8'(main_y), 8'(c >= 8 && c <= 10));
         chk("early_walk", 8'(ped_walk), 8'(c >= 13 && c <= 17));
         if (c == 3) chk("early_req", 8'(req_pending), 8'd1);
         if (c >= 11 && c <= 12) chk("early_allred", 8'(main_r & ped_dw), 8'd1);
`ifdef PED_FLASH_EN
         if (c >= 18 && c <= 21) chk("early_flash", 8'(ped_dw), 8'(c % 2 == 0));
`endif
         tick(c == 2, 1'b0);
      end

      // Late request
      do_reset();
      for (int c = 0; c < 30; c++) begin
         chk("late_g", 8'(main_g), 8'(c < 22));
         chk("late_y", 8'(main_y), 8'(c >= 22 && c <= 24));
         if (c == 20) chk("late_req0", 8'(req_pending), 8'd0);
         if (c == 21) chk("late_req1", 8'(req_pending), 8'd1);
         tick(c == 20, 1'b0);
      end

      // No request
      do_reset();
      for (int c = 0; c < 100; c++) begin
         chk("idle_state", 8'(state), 8'd0);
         chk("idle_g_dw", 8'({main_g, ped_dw}), 8'd3);
         tick(1'b0, 1'b0);
      end

      // Button held through service
      do_reset();
      for (int c = 0; c <= 60; c++) begin
         if (c == 13) chk("hold_req_clr", 8'(req_pending), 8'd0);
         if (c <= RET + GREEN_MIN + 2)
            chk("hold_y", 8'(main_y),
                8'((c >= 8 && c <= 10) || (c >= RET + GREEN_MIN)));
         tick(c <= 40, 1'b0);
      end

      // Button only during walk
      do_reset();
      for (int c = 0; c <= 60; c++) begin
         if (c >= RET) chk("walkbtn_g", 8'(main_g), 8'd1);
         if (c >= 13) chk("walkbtn_req", 8'(req_pending), 8'd0);
         tick((c == 2) || (c >= 13 && c <= 17), 1'b0);
      end

      // Reset mid-walk
      do_reset();
      for (int c = 0; c <= 40; c++) begin
         if (c == 15) chk("midrst_walk", 8'(ped_walk), 8'd1);
         if (c == 16) begin
            chk("midrst_state", 8'(state), 8'd0);
            chk("midrst_g_dw", 8'({main_g, ped_dw}), 8'd3);
            chk("midrst_req", 8'(req_pending), 8'd0);
         end
         if (c >= 16 && c <= 23) chk("midrst_noy", 8'(main_y), 8'd0);
         if (c == 24) chk("midrst_y", 8'(main_y), 8'd1);
         tick((c == 2) || (c >= 16), c == 15);
      end

      // Random traffic
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         tick($urandom_range(0, 2) == 0, $urandom_range(0, 999) == 0);
      end
      check_model();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
